// File: rtl/gray_cnt_pkg.sv
// Shared encodings and helpers for the Gray-coded pulse counter.
// Imported by the edge detector and the counter top.
package gray_cnt_pkg;

   localparam int EDGE_RISE  = 0;
   localparam int EDGE_FALL  = 1;
   localparam int EDGE_BOTH  = 2;
   localparam int GRAY_MAX_W = 16;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } cnt_op_e;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ {1'b0, bin[GRAY_MAX_W-1:1]};
   endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Synchronizes an asynchronous pulse and qualifies its edges.
// The event comes from the last sync stage against one history flop.
module pulse_edge_det
   import gray_cnt_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse,
   output logic evt
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   hist_r;
   logic                   rise_s;
   logic                   fall_s;
   logic                   evt_s;

   // Synchronizer chain plus history flop; runs every cycle, cleared by rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         hist_r <= 1'b0;
      end else begin
         sync_r[0] <= pulse;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         hist_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Edge qualification; all inputs are flops so evt has no input-to-output path.
   always_comb begin
      rise_s = sync_r[SYNC_STAGES-1] & ~hist_r;
      fall_s = ~sync_r[SYNC_STAGES-1] & hist_r;
      case (EDGE_MODE)
         EDGE_RISE: evt_s = rise_s;
         EDGE_FALL: evt_s = fall_s;
         EDGE_BOTH: evt_s = rise_s | fall_s;
         default:   evt_s = rise_s;
      endcase
   end

   assign evt = evt_s;

endmodule

// File: rtl/gray_pulse_counter.sv
// Up/down pulse counter with binary and Gray outputs, terminal-count strobe
// and sticky limit flag; wrap or saturate at the limits.
module gray_pulse_counter
   import gray_cnt_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int EDGE_MODE   = 0,
   parameter int SATURATE    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count_bin,
   output logic [WIDTH-1:0] count_gray,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             evt_s;
   cnt_op_e          op_s;
   logic [WIDTH-1:0] next_bin_s;
   logic [WIDTH-1:0] next_gray_s;
   logic             next_tc_s;
   logic             next_ovf_s;

   logic [WIDTH-1:0] count_bin_r;
   logic [WIDTH-1:0] count_gray_r;
   logic             tc_r;
   logic             ovf_r;

   pulse_edge_det #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
   ) u_edge_det (
      .clk  (clk),
      .rst  (rst),
      .pulse(pulse),
      .evt  (evt_s)
   );

   // Operation select: load beats a counted edge; an edge with en low is lost.
   always_comb begin
      op_s = OP_HOLD;
      if (load) begin
         op_s = OP_LOAD;
      end else if (en && evt_s) begin
         op_s = dir ? OP_INC : OP_DEC;
      end else begin
         op_s = OP_HOLD;
      end
   end

   // Next-state count, strobe and sticky flag, including limit handling.
   always_comb begin
      next_bin_s = count_bin_r;
      next_tc_s  = 1'b0;
      next_ovf_s = ovf_r;
      case (op_s)
         OP_LOAD: begin
            next_bin_s = load_val;
            next_ovf_s = 1'b0;
         end
         OP_INC: begin
            if (count_bin_r == MAX_VAL) begin
               next_tc_s  = 1'b1;
               next_ovf_s = 1'b1;
               next_bin_s = (SATURATE != 0) ? count_bin_r : MIN_VAL;
            end else begin
               next_bin_s = count_bin_r + ONE_VAL;
            end
         end
         OP_DEC: begin
            if (count_bin_r == MIN_VAL) begin
               next_tc_s  = 1'b1;
               next_ovf_s = 1'b1;
               next_bin_s = (SATURATE != 0) ? count_bin_r : MAX_VAL;
            end else begin
               next_bin_s = count_bin_r - ONE_VAL;
            end
         end
         default: begin
            next_bin_s = count_bin_r;
         end
      endcase
   end

   // Gray code is formed from the next binary value so both outputs move together.
   always_comb begin
      next_gray_s = WIDTH'(bin2gray(GRAY_MAX_W'(next_bin_s)));
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_bin_r  <= MIN_VAL;
         count_gray_r <= MIN_VAL;
         tc_r         <= 1'b0;
         ovf_r        <= 1'b0;
      end else begin
         count_bin_r  <= next_bin_s;
         count_gray_r <= next_gray_s;
         tc_r         <= next_tc_s;
         ovf_r        <= next_ovf_s;
      end
   end

   assign count_bin  = count_bin_r;
   assign count_gray = count_gray_r;
   assign tc         = tc_r;
   assign ovf        = ovf_r;

endmodule

// File: tb/tb_gray_pulse_counter.sv
// Bench for gray_pulse_counter: several parameter variants share one stimulus
// stream and are checked every cycle against a history-based reference model.
module tb_gray_pulse_counter;

   localparam int N = 7;
   localparam int W_P   [N] = '{4, 4, 4, 4, 7, 7, 7};
   localparam int E_P   [N] = '{0, 0, 2, 1, 2, 0, 1};
   localparam int SAT_P [N] = '{0, 1, 0, 0, 0, 1, 0};
   localparam int S_P   [N] = '{2, 2, 2, 2, 2, 3, 1};

   logic       clk = 1'b0;
   logic       rst, pulse, en, dir, load;
   logic [6:0] lv;

   logic [15:0]  bin_o  [N];
   logic [15:0]  gray_o [N];
   logic [N-1:0] tc_o;
   logic [N-1:0] ovf_o;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      logic [W_P[gi]-1:0] b;
      logic [W_P[gi]-1:0] g;
      gray_pulse_counter #(
         .WIDTH(W_P[gi]), .EDGE_MODE(E_P[gi]), .SATURATE(SAT_P[gi]), .SYNC_STAGES(S_P[gi])
      ) u_dut (
         .clk(clk), .rst(rst), .pulse(pulse), .en(en), .dir(dir), .load(load),
         .load_val(lv[W_P[gi]-1:0]), .count_bin(b), .count_gray(g),
         .tc(tc_o[gi]), .ovf(ovf_o[gi])
      );
      assign bin_o[gi]  = 16'(b);
      assign gray_o[gi] = 16'(g);
   end

   int total = 0;
   int bad   = 0;

   // reference model state: pulse sample history plus per-variant count state
   bit samp [16384];
   int last_rst = -1;
   int t = 0;
   int m_cnt  [N];
   bit m_tc   [N];
   bit m_ovf  [N];
   bit m_step [N];
   int prev_gray [N];

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, t);
      end
   endfunction

   // level of the sample taken at edge j, as seen now; a reset since then wipes it
   function automatic bit vis(int j);
      return (j < 0 || j <= last_rst) ? 1'b0 : samp[j];
   endfunction

   // predict every variant's state after the upcoming rising edge
   function automatic void model_step();
      bit cur, prv, ev;
      int lim, nxt;
      samp[t] = pulse;
      for (int i = 0; i < N; i++) begin
         cur = vis(t - S_P[i]);
         prv = vis(t - S_P[i] - 1);
         if (E_P[i] == 0)      ev = cur && !prv;
         else if (E_P[i] == 1) ev = !cur && prv;
         else                  ev = (cur != prv);
         lim = (1 << W_P[i]) - 1;
         m_step[i] = 1'b0;
         if (rst) begin
            m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
         end else if (load) begin
            m_cnt[i] = int'(lv) & lim; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
         end else if (en && ev) begin
            nxt = dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
            if (nxt > lim || nxt < 0) begin
               m_tc[i] = 1'b1; m_ovf[i] = 1'b1;
               if (SAT_P[i] == 0) begin
                  m_cnt[i] = nxt & lim; m_step[i] = 1'b1;
               end
            end else begin
               m_cnt[i] = nxt; m_tc[i] = 1'b0; m_step[i] = 1'b1;
            end
         end else begin
            m_tc[i] = 1'b0;
         end
      end
      if (rst) last_rst = t;
      t++;
   endfunction

   function automatic void check_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("bin[%0d]", i), int'(bin_o[i]), m_cnt[i]);
         chk($sformatf("gray[%0d]", i), int'(gray_o[i]), m_cnt[i] ^ (m_cnt[i] >> 1));
         chk($sformatf("tc[%0d]", i), int'(tc_o[i]), int'(m_tc[i]));
         chk($sformatf("ovf[%0d]", i), int'(ovf_o[i]), int'(m_ovf[i]));
         if (m_step[i]) begin
            chk($sformatf("gray_onebit[%0d]", i), $countones(gray_o[i] ^ 16'(prev_gray[i])), 1);
         end
         prev_gray[i] = int'(gray_o[i]);
      end
   endfunction

   // inputs are set at the falling edge; predict, clock, then compare at the next falling edge
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic full_pulse(int hi, int lo);
      pulse = 1'b1;
      repeat (hi) tick();
      pulse = 1'b0;
      repeat (lo) tick();
   endtask

   logic [3:0] gseq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

   initial begin
      int tcn;
      rst = 1'b1; pulse = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; lv = 7'd0;
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0; m_step[i] = 1'b0; prev_gray[i] = 0;
      end
      @(negedge clk);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_bin", int'(bin_o[0]), 0);
      chk("reset_gray", int'(gray_o[0]), 0);
      chk("reset_tc", int'(tc_o[0]), 0);
      chk("reset_ovf", int'(ovf_o[0]), 0);

      // 16 rising pulses: Gray walk, two-edge latency, wrap strobe
      en = 1'b1; dir = 1'b1;
      for (int k = 0; k < 16; k++) begin
         pulse = 1'b1;
         tick();
         chk("latency_edge1", int'(gray_o[0]), int'(gseq[k]));
         tick();
         chk("latency_edge2", int'(gray_o[0]), int'(gseq[k]));
         tick();
         chk("gray_walk", int'(gray_o[0]), int'(gseq[k+1]));
         if (k == 15) begin
            chk("wrap_tc", int'(tc_o[0]), 1);
            chk("wrap_ovf", int'(ovf_o[0]), 1);
         end
         pulse = 1'b0;
         repeat (3) tick();
      end
      chk("wrap_tc_drop", int'(tc_o[0]), 0);
      chk("wrap_ovf_sticky", int'(ovf_o[0]), 1);
      chk("model_pin_wrap", m_cnt[0], 0);

      // saturating down count from a load of 2
      lv = 7'd2; load = 1'b1;
      tick();
      load = 1'b0; dir = 1'b0;
      chk("sat_load", int'(bin_o[1]), 2);
      chk("sat_load_ovf", int'(ovf_o[1]), 0);
      for (int k = 0; k < 3; k++) begin
         tcn = 0;
         pulse = 1'b1;
         repeat (3) begin tick(); tcn += int'(tc_o[1]); end
         pulse = 1'b0;
         repeat (3) begin tick(); tcn += int'(tc_o[1]); end
         chk("sat_bin", int'(bin_o[1]), (k == 0) ? 1 : 0);
         chk("sat_tc_count", tcn, (k == 2) ? 1 : 0);
      end
      chk("sat_ovf", int'(ovf_o[1]), 1);
      chk("model_pin_sat", m_cnt[1], 0);

      // edge modes: two full pulses after reset
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0; dir = 1'b1;
      full_pulse(3, 4);
      full_pulse(3, 4);
      chk("both_edges", int'(bin_o[2]), 4);
      chk("fall_edges", int'(bin_o[3]), 2);
      chk("rise_edges", int'(bin_o[0]), 2);
      chk("model_pin_both", m_cnt[2], 4);

      // edge with en low is discarded, not queued
      en = 1'b0;
      full_pulse(3, 3);
      en = 1'b1;
      repeat (6) tick();
      chk("en_drop_rise", int'(bin_o[0]), 2);
      chk("en_drop_both", int'(bin_o[2]), 4);

      // wrap down to set ovf, then load collides with a counted edge
      lv = 7'd0; load = 1'b1; dir = 1'b0;
      tick();
      load = 1'b0;
      full_pulse(3, 3);
      chk("down_wrap_bin", int'(bin_o[0]), 15);
      chk("down_wrap_ovf", int'(ovf_o[0]), 1);
      pulse = 1'b1;
      repeat (2) tick();
      lv = 7'd9; load = 1'b1;
      tick();
      load = 1'b0;
      repeat (4) tick();
      pulse = 1'b0;
      repeat (4) tick();
      chk("load_wins_bin", int'(bin_o[0]), 9);
      chk("load_wins_gray", int'(gray_o[0]), 13);
      chk("load_clr_ovf", int'(ovf_o[0]), 0);

      // reset one cycle after a pulse rise drops the edge in flight
      dir = 1'b1;
      pulse = 1'b1;
      tick();
      rst = 1'b1; pulse = 1'b0;
      tick();
      chk("rst_mid_bin", int'(bin_o[0]), 0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("rst_drop_bin", int'(bin_o[0]), 0);
      chk("rst_drop_gray", int'(gray_o[0]), 0);
      chk("rst_drop_tc", int'(tc_o[0]), 0);
      chk("rst_drop_ovf", int'(ovf_o[0]), 0);

      // randomized traffic
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(2) == 0) pulse = ~pulse;
         en = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) dir = ~dir;
         load = ($urandom_range(39) == 0);
         lv = 7'($urandom);
         rst = ($urandom_range(299) == 0);
         tick();
      end
      rst = 1'b0; load = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
